cpe_lsu: RTL
============

# cpe_lsu

Load/store unit between the cpe_cpu core's memory-control outputs and a word-wide, request/grant data bus. It turns a core load or store into one aligned bus transaction. It steers bytes for SB/SH/SW stores and generates byte enables. It extracts and sign- or zero-extends load data for LB/LH/LW/LBU/LHU, and stalls the core until the access completes. Misaligned and malformed accesses are trapped locally and never reach the bus.

## Interface
- No parameters; address and data widths are fixed at 32 (RV32I).

- clk_w_i  in  1  core clock; all state changes on rising edge
- res_w_i_h  in  1  reset, synchronous, active-high
- mem_rd_w_i_h  in  1  core load request; held with all core inputs stable while stall_w_o_h=1
- mem_wr_w_i_h  in  1  core store request; same hold rule
- funct_3_w_i  in  3  instr[14:12]: access size/sign
- addr_w_i  in  32  byte address (ALU result)
- wr_data_w_i  in  32  store data (rs2), right-justified
- rd_data_w_o  out  32  extended load result; valid only in DONE
- stall_w_o_h  out  1  freeze core PC/writeback
- err_w_o_h  out  1  one-cycle pulse on a misaligned or illegal access
- bus_req_w_o_h  out  1  bus request, registered
- bus_we_w_o_h  out  1  1 = write, registered
- bus_addr_w_o  out  32  {addr[31:2],2'b00}, registered
- bus_be_w_o  out  4  byte enables, registered
- bus_wdata_w_o  out  32  lane-steered store data, registered
- bus_gnt_w_i_h  in  1  bus accepts the request this cycle
- bus_rvalid_w_i_h  in  1  read data valid; at least 1 cycle after grant
- bus_rdata_w_i  in  32  read word

## Operation
- States: IDLE, REQ, WAIT_R, DONE, ERR.
- IDLE, no request: the FSM stays in IDLE.
- IDLE, legal request: latch the bus outputs, funct3 and addr[1:0], then go to REQ.
- IDLE, illegal request: go to ERR. Illegal means any of:
  - mem_rd and mem_wr both high;
  - load funct3 in {011, 110, 111};
  - store funct3 not in {000, 001, 010};
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0.
- REQ: bus_req_w_o_h=1. With gnt, a write goes to DONE and a read goes to WAIT_R. Without gnt, stay in REQ with the bus outputs held.
- WAIT_R: on rvalid, capture the extracted/extended data into rd_data_w_o and go to DONE.
- DONE: a single cycle, then IDLE.
- ERR: err_w_o_h=1 for one cycle, then IDLE.
- rd_data_w_o holds its last value outside DONE. It is 0 after an ERR.
- Byte enables:
  - SB/LB/LBU: be = 4'b0001 << addr[1:0].
  - SH/LH/LHU: be = 4'b0011 << {addr[1],1'b0}.
  - SW/LW: be = 4'b1111.
- Store data: SB replicates the byte to all 4 lanes; SH replicates the halfword to both halves; SW passes data through.
- Load extract:
  - Byte lane = rdata[8*addr[1:0] +: 8].
  - Halfword = rdata[16*addr[1] +: 16].
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- stall_w_o_h = request present in IDLE (legal or not), or state ∈ {REQ, WAIT_R}. It is low in DONE and ERR, and forced 0 while res_w_i_h=1.
- rvalid arriving in IDLE, REQ, DONE or ERR is ignored.

## Timing
- Reset: state becomes IDLE, and every registered output (bus_*, rd_data_w_o, err_w_o_h) is 0 on the first edge with res high.
- Reset mid-transaction: bus_req drops at that edge, with no completion and no err. A stale rvalid after reset is ignored.
- Store, zero-wait grant: 3 cycles (IDLE, REQ, DONE); stall is high for 2 cycles.
- Load, grant plus rvalid 1 cycle later: 4 cycles (IDLE, REQ, WAIT_R, DONE); stall is high for 3 cycles.
- Each cycle without gnt or rvalid adds one cycle of stall. There is no timeout.
- Back-to-back accesses: the request seen in the DONE cycle belongs to the completed instruction. A new access begins only from IDLE, so throughput is at most one access per 3 cycles.
- The bus_* outputs are stable from REQ entry until the grant edge.

## Structure
- Shared package cpe_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - the lsu_state_t enum (IDLE, REQ, WAIT_R, DONE, ERR).
- One combinational sub-module, lsu_align, covers byte-enable generation, store lane steering, load extraction/extension and the legality check. It is shared with the bench reference model.
- cpe_lsu holds the FSM and the output registers.

## Test plan
- SB to addr 0x103, data 0x000000A5, gnt immediate → bus_addr=0x100, be=4'b1000, wdata=0xA5A5A5A5; stall high 2 cycles; no err.
- LB from 0x102, rdata=0x0080FF00 → rd_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU from 0x102 → 0x00000080. LH from 0x102 → 0x00000080.
- LW from 0x200, gnt delayed 3 cycles, rvalid 2 cycles after gnt → bus_req held 4 cycles, stall high for 7 cycles, rd_data=rdata in DONE.
- SW to 0x201 → ERR. SH to 0x301 → ERR. mem_rd with funct3=3'b011 → ERR. In each case err pulses once, bus_req is never asserted, and stall is high exactly 1 cycle.
- Reset asserted while in WAIT_R, then rvalid pulses → state IDLE, all outputs 0, rvalid ignored, no DONE.
- mem_rd and mem_wr both high → ERR with no bus activity.
- Back-to-back SW then LW with zero-wait bus → second request starts from IDLE; no request overlap; bus_we changes only at the REQ entry edge.

Source files
------------

// File: rtl/cpe_pkg.sv
// Shared definitions for the cpe core and its load/store unit.
package cpe_pkg;

   // funct3 encodings for loads and stores (instr[14:12])
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT_R = 3'd2,
      DONE   = 3'd3,
      ERR    = 3'd4
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath for the LSU: legality check, byte enables,
// store lane steering and load extraction/extension.
// Store-side inputs come from the live core request; load-side inputs
// come from the funct3/addr[1:0] latched when the request was issued.
module lsu_align
   import cpe_pkg::*;
(
   input  logic        i_rd,
   input  logic        i_wr,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wr_data,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ld_data,
   output logic        o_illegal
);

   logic        w_ld_ok;
   logic        w_st_ok;
   logic        w_misalign;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sext;

   // legality of the live request: size/sign encoding and natural alignment
   always_comb begin
      w_ld_ok = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
      w_st_ok = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
      case (i_funct3[1:0])
         2'b01:   w_misalign = i_addr_lo[0];
         2'b10:   w_misalign = |i_addr_lo;
         default: w_misalign = 1'b0;
      endcase
      o_illegal = (i_rd & i_wr) | (i_rd & ~w_ld_ok) | (i_wr & ~w_st_ok) |
                  ((i_rd | i_wr) & w_misalign);
   end

   // byte enables and store lane replication
   always_comb begin
      case (i_funct3[1:0])
         2'b00: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wr_data[7:0]}};
         end
         2'b01: begin
            o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata = {2{i_wr_data[15:0]}};
         end
         default: begin
            o_be    = 4'b1111;
            o_wdata = i_wr_data;
         end
      endcase
   end

   // pick the addressed lane of the read word and extend it
   always_comb begin
      case (i_ld_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      w_sext = ~i_ld_funct3[2];
      case (i_ld_funct3[1:0])
         2'b00:   o_ld_data = {{24{w_sext & w_byte[7]}}, w_byte};
         2'b01:   o_ld_data = {{16{w_sext & w_half[15]}}, w_half};
         default: o_ld_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/cpe_lsu.sv
// Load/store unit: turns one core load/store into one aligned bus
// transaction, stalling the core until it completes.
//
// state  | meaning
// IDLE   | waiting for a core request; illegal ones divert to ERR
// REQ    | bus request asserted, bus fields held until grant
// WAIT_R | read granted, waiting for read data
// DONE   | access complete for one cycle, core released
// ERR    | one-cycle error pulse, nothing sent to the bus
module cpe_lsu
   import cpe_pkg::*;
(
   input  logic        clk_w_i,
   input  logic        res_w_i_h,
   input  logic        mem_rd_w_i_h,
   input  logic        mem_wr_w_i_h,
   input  logic [2:0]  funct_3_w_i,
   input  logic [31:0] addr_w_i,
   input  logic [31:0] wr_data_w_i,
   output logic [31:0] rd_data_w_o,
   output logic        stall_w_o_h,
   output logic        err_w_o_h,
   output logic        bus_req_w_o_h,
   output logic        bus_we_w_o_h,
   output logic [31:0] bus_addr_w_o,
   output logic [3:0]  bus_be_w_o,
   output logic [31:0] bus_wdata_w_o,
   input  logic        bus_gnt_w_i_h,
   input  logic        bus_rvalid_w_i_h,
   input  logic [31:0] bus_rdata_w_i
);

   lsu_state_t  r_state;
   lsu_state_t  w_state_nxt;
   logic [2:0]  r_funct3;
   logic [1:0]  r_addr_lo;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_rd_data;
   logic        w_req;
   logic        w_illegal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ld_data;

   assign w_req = mem_rd_w_i_h | mem_wr_w_i_h;

   lsu_align u_align (
      .i_rd         (mem_rd_w_i_h),
      .i_wr         (mem_wr_w_i_h),
      .i_funct3     (funct_3_w_i),
      .i_addr_lo    (addr_w_i[1:0]),
      .i_wr_data    (wr_data_w_i),
      .i_ld_funct3  (r_funct3),
      .i_ld_addr_lo (r_addr_lo),
      .i_rdata      (bus_rdata_w_i),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_ld_data    (w_ld_data),
      .o_illegal    (w_illegal)
   );

   // state register
   always_ff @(posedge clk_w_i) begin
      if (res_w_i_h) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req) w_state_nxt = w_illegal ? ERR : REQ;
         REQ:     if (bus_gnt_w_i_h) w_state_nxt = r_we ? DONE : WAIT_R;
         WAIT_R:  if (bus_rvalid_w_i_h) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         ERR:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs; stall covers the request cycle in IDLE so the
   // core freezes before the FSM has even left IDLE
   always_comb begin
      bus_req_w_o_h = (r_state == REQ);
      err_w_o_h     = (r_state == ERR);
      stall_w_o_h   = ~res_w_i_h &
                      (((r_state == IDLE) & w_req) | (r_state == REQ) | (r_state == WAIT_R));
   end

   // bus fields latched only on IDLE->REQ so they stay put until grant;
   // load result captured on rvalid in WAIT_R and cleared on an illegal access
   always_ff @(posedge clk_w_i) begin
      if (res_w_i_h) begin
         r_funct3  <= 3'b000;
         r_addr_lo <= 2'b00;
         r_we      <= 1'b0;
         r_addr    <= 32'h0;
         r_be      <= 4'h0;
         r_wdata   <= 32'h0;
         r_rd_data <= 32'h0;
      end else begin
         if ((r_state == IDLE) && w_req && !w_illegal) begin
            r_funct3  <= funct_3_w_i;
            r_addr_lo <= addr_w_i[1:0];
            r_we      <= mem_wr_w_i_h;
            r_addr    <= {addr_w_i[31:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
         end
         if ((r_state == IDLE) && w_req && w_illegal) r_rd_data <= 32'h0;
         if ((r_state == WAIT_R) && bus_rvalid_w_i_h) r_rd_data <= w_ld_data;
      end
   end

   assign bus_we_w_o_h  = r_we;
   assign bus_addr_w_o  = r_addr;
   assign bus_be_w_o    = r_be;
   assign bus_wdata_w_o = r_wdata;
   assign rd_data_w_o   = r_rd_data;

endmodule
